// File: rtl/cmd_input_queue.sv
// Game command queue: merges UART key bytes and push-button events
// (edge + DAS/ARR auto-repeat) into one FIFO drained by the game FSM.
package enum_type;
    typedef enum logic [2:0] {
        NONE,
        LEFT,
        RIGHT,
        DOWN,
        DROP,
        HOLD,
        ROTATE,
        ROTATE_REV
    } state_type;
endpackage

module cmd_input_queue
    import enum_type::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         DAS_DELAY   = 12_000_000,
    parameter int         ARR_PERIOD  = 3_000_000,
    parameter logic [3:0] REPEAT_MASK = 4'b0111
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               btn,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    input  logic                     pop,
    input  logic                     flush,
    output state_type                cmd,
    output logic                     cmd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DAS_DELAY + 1);
    localparam logic [CW-1:0] DAS_C  = CW'(DAS_DELAY);
    localparam logic [CW-1:0] RELOAD = CW'(DAS_DELAY - ARR_PERIOD + 1);
    localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

    function automatic state_type map_rx(input logic [7:0] b);
        state_type c;
        c = NONE;
        case (b)
            "A", "a":      c = LEFT;
            "D", "d":      c = RIGHT;
            "S", "s":      c = DOWN;
            "W", "w", " ": c = DROP;
            "C", "c":      c = HOLD;
            "X", "x":      c = ROTATE;
            "Z", "z":      c = ROTATE_REV;
            default:       c = NONE;
        endcase
        return c;
    endfunction

    function automatic state_type map_btn(input int i);
        state_type c;
        case (i)
            0:       c = RIGHT;
            1:       c = DOWN;
            2:       c = LEFT;
            default: c = ROTATE;
        endcase
        return c;
    endfunction

    state_type       mem_q [DEPTH];
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [7:0]      drop_q, drop_d;
    logic [3:0]      pend_q, pend_d;
    logic [3:0]      prev_q;
    logic [CW-1:0]   hold_q [4];
    logic [CW-1:0]   hold_d [4];

    logic [3:0]      ev;
    logic [3:0]      sel_oh;
    logic [3:0]      serve;
    logic            pend_hit;
    state_type       pend_cmd;
    state_type       rx_cmd;
    state_type       push_cmd;
    logic            rx_hit, push_req, room;
    logic            do_pop, do_push, do_drop;

    // Hold counter equals the hold index; on reaching DAS it reloads so
    // the next match lands exactly ARR_PERIOD cycles later.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ev[i]     = 1'b0;
            hold_d[i] = hold_q[i];
            if (!btn[i]) begin
                hold_d[i] = '0;
            end else if (!prev_q[i]) begin
                ev[i]     = 1'b1;
                hold_d[i] = REPEAT_MASK[i] ? CW'(1) : '0;
            end else if (REPEAT_MASK[i]) begin
                if (hold_q[i] == DAS_C) begin
                    ev[i]     = 1'b1;
                    hold_d[i] = RELOAD;
                end else begin
                    hold_d[i] = hold_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        sel_oh   = '0;
        pend_hit = 1'b0;
        pend_cmd = NONE;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_oh   = 4'b0001 << i;
                pend_hit = 1'b1;
                pend_cmd = map_btn(i);
            end
        end
    end

    always_comb begin
        rx_cmd   = map_rx(rx_byte);
        rx_hit   = rx_valid && (rx_cmd != NONE);
        push_req = rx_hit || pend_hit;
        push_cmd = rx_hit ? rx_cmd : pend_cmd;
        serve    = rx_hit ? 4'b0000 : sel_oh;
        do_pop   = pop && (cnt_q != '0) && !flush;
        room     = (cnt_q != FULL_C) || do_pop;
        do_push  = push_req && room && !flush;
        do_drop  = push_req && !room && !flush;

        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        pend_d = (pend_q & ~serve) | ev;

        if (flush) begin
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
            pend_d = '0;
        end else begin
            if (do_pop)
                rd_d = rd_q + AW'(1);
            if (do_push)
                wr_d = wr_q + AW'(1);
            if (do_push && !do_pop)
                cnt_d = cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push)
                cnt_d = cnt_q - (AW+1)'(1);
            if (do_drop && drop_q != 8'hFF)
                drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
            for (int i = 0; i < 4; i++)
                hold_q[i] <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            pend_q <= pend_d;
            prev_q <= btn;
            for (int i = 0; i < 4; i++)
                hold_q[i] <= hold_d[i];
        end
    end

    // Storage needs no reset: the head is masked by the count.
    always_ff @(posedge clk) begin
        if (reset_n && do_push)
            mem_q[wr_q] <= push_cmd;
    end

    assign cmd       = (cnt_q != '0) ? mem_q[rd_q] : NONE;
    assign cmd_valid = (cnt_q != '0);
    assign count     = cnt_q;
    assign full      = (cnt_q == FULL_C);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_cmd_input_queue.sv
// Scoreboard bench for cmd_input_queue: driver pushes expected entries,
// a negedge monitor checks every accepted pop against them.
module tb_cmd_input_queue;
    import enum_type::*;

    localparam int DEPTH = 4;

    logic       clk = 0;
    logic       reset_n = 0;
    logic [3:0] btn = '0;
    logic       rx_valid = 0;
    logic [7:0] rx_byte = '0;
    logic       pop = 0;
    logic       flush = 0;
    state_type  cmd;
    logic       cmd_valid;
    logic [2:0] count;
    logic       full;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    cmd_input_queue #(
        .DEPTH(DEPTH),
        .DAS_DELAY(10),
        .ARR_PERIOD(4),
        .REPEAT_MASK(4'b0111)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn(btn),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .pop(pop),
        .flush(flush),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .count(count),
        .full(full),
        .drop_cnt(drop_cnt)
    );

    int        n_cmp = 0;
    int        n_bad = 0;
    state_type exp_q[$];
    int        mcount = 0;
    int        mdrop = 0;
    bit        cnt_chk = 0;

    function automatic state_type ref_map(input logic [7:0] b);
        case (b)
            "A", "a":      return LEFT;
            "D", "d":      return RIGHT;
            "S", "s":      return DOWN;
            "W", "w", " ": return DROP;
            "C", "c":      return HOLD;
            "X", "x":      return ROTATE;
            "Z", "z":      return ROTATE_REV;
            default:       return NONE;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && pop && !flush && cmd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_order: got %0d expected nothing",
                         int'(cmd));
            end else begin
                chk("pop_order", int'(cmd), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic rv, input logic [7:0] rb,
                        input logic pp, input logic fl);
        int        pre;
        bit        pv;
        state_type c;
        rx_valid = rv;
        rx_byte  = rb;
        pop      = pp;
        flush    = fl;
        pre = mcount;
        pv  = pp && (mcount > 0);
        c   = rv ? ref_map(rb) : NONE;
        if (fl) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (pv)
                mcount--;
            if (c != NONE) begin
                if (pre < DEPTH || pv) begin
                    exp_q.push_back(c);
                    mcount++;
                end else if (mdrop < 255) begin
                    mdrop++;
                end
            end
        end
        @(negedge clk);
        if (cnt_chk) begin
            chk("count", int'(count), pre);
            chk("cmd_valid", int'(cmd_valid), int'(pre != 0));
            chk("full", int'(full), int'(pre == DEPTH));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic chk_reset(input string nm);
        @(negedge clk);
        chk({nm, "_count"}, int'(count), 0);
        chk({nm, "_cmd"}, int'(cmd), int'(NONE));
        chk({nm, "_valid"}, int'(cmd_valid), 0);
        chk({nm, "_full"}, int'(full), 0);
        chk({nm, "_drop"}, int'(drop_cnt), 0);
    endtask

    logic [7:0] tbl [10] = '{"a", "D", "s", "W", " ", "c", "X", "z", "q", "1"};

    initial begin
        reset_n = 0;
        @(posedge clk);
        #1;
        chk_reset("reset");
        @(posedge clk);
        #1;
        reset_n = 1;
        cnt_chk = 1;

        // UART mapping, latency and order
        step(1, "d", 0, 0);
        step(1, "A", 0, 0);
        step(1, "z", 0, 0);
        step(1, "q", 0, 0);
        idle(1);
        pops(4);
        @(negedge clk);
        chk("empty_cmd", int'(cmd), int'(NONE));
        chk("uart_drop", int'(drop_cnt), 0);
        @(posedge clk);
        #1;

        // Auto-repeat LEFT: indices 0, 10, 14, 18
        cnt_chk = 0;
        btn = 4'b0100;
        idle(20);
        btn = 4'b0000;
        idle(2);
        repeat (4) exp_q.push_back(LEFT);
        mcount = 4;
        cnt_chk = 1;
        idle(1);
        pops(4);

        // ROTATE does not repeat
        cnt_chk = 0;
        btn = 4'b1000;
        idle(20);
        btn = 4'b0000;
        idle(2);
        exp_q.push_back(ROTATE);
        mcount = 1;
        cnt_chk = 1;
        idle(1);
        pops(1);

        // UART beats the simultaneous button edge; neither lost
        cnt_chk = 0;
        btn = 4'b0001;
        step(1, "s", 0, 0);
        idle(1);
        btn = 4'b0000;
        exp_q.push_back(RIGHT);
        mcount++;
        cnt_chk = 1;
        idle(1);
        pops(2);

        // Full handling
        for (int i = 0; i < 6; i++)
            step(1, "w", 0, 0);
        idle(1);
        @(negedge clk);
        chk("full_drop", int'(drop_cnt), mdrop);
        chk("full_drop_two", int'(drop_cnt), 2);
        @(posedge clk);
        #1;
        step(1, "w", 1, 0);
        idle(1);
        @(negedge clk);
        chk("pushpop_drop", int'(drop_cnt), 2);
        @(posedge clk);
        #1;
        pops(4);

        // Flush wins over a same-cycle push
        for (int i = 0; i < 3; i++)
            step(1, "a", 0, 0);
        step(1, "a", 0, 1);
        idle(1);
        @(negedge clk);
        chk("flush_cmd", int'(cmd), int'(NONE));
        chk("flush_drop", int'(drop_cnt), 2);
        @(posedge clk);
        #1;

        // Reset while a button is held
        cnt_chk = 0;
        btn = 4'b0100;
        idle(12);
        reset_n = 0;
        btn = 4'b0000;
        @(posedge clk);
        #1;
        chk_reset("midreset");
        @(posedge clk);
        #1;
        reset_n = 1;
        exp_q.delete();
        mcount = 0;
        mdrop = 0;
        cnt_chk = 1;

        // Drop counter saturation
        for (int i = 0; i < 304; i++)
            step(1, "w", 0, 0);
        idle(1);
        @(negedge clk);
        chk("drop_sat", int'(drop_cnt), 255);
        @(posedge clk);
        #1;
        step(0, 8'h00, 0, 1);

        // Random traffic against the reference queue
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), tbl[$urandom_range(0, 9)],
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        pops(DEPTH + 1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end
        @(negedge clk);
        chk("rand_drop", int'(drop_cnt), mdrop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
